// File: rtl/startup_sequencer_pkg.sv
// Shared types and constants for the startup sequencer: state encoding,
// counter width and the per-state output decode.
package startup_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD_GSR  = 3'd2,
        ST_HOLD_GTS  = 3'd3,
        ST_HOLD_GWE  = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    typedef struct packed {
        logic gsr;
        logic gts;
        logic gwe;
        logic done;
        logic fault;
    } outs_t;

    localparam outs_t OUT_ALL_HELD = 5'b11000;
    localparam outs_t OUT_GTS_HELD = 5'b01000;
    localparam outs_t OUT_RELEASED = 5'b00000;
    localparam outs_t OUT_DONE     = 5'b00110;
    localparam outs_t OUT_FAULT    = 5'b11001;

    function automatic outs_t decode_outputs(input state_t s);
        outs_t o;
        case (s)
            ST_IDLE, ST_WAIT_LOCK, ST_HOLD_GSR: o = OUT_ALL_HELD;
            ST_HOLD_GTS:                        o = OUT_GTS_HELD;
            ST_HOLD_GWE:                        o = OUT_RELEASED;
            ST_DONE:                            o = OUT_DONE;
            ST_FAULT:                           o = OUT_FAULT;
            default:                            o = OUT_ALL_HELD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/startup_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/startup_sequencer.sv
// Power-up sequencer: waits for PLL lock, then releases GSR/PRLD, GTS and
// finally enables GWE, with lock-loss recovery and a lock timeout fault.
//
// state      | meaning
// IDLE       | waiting for start, everything held
// WAIT_LOCK  | waiting for synchronized lock, timeout counting
// HOLD_GSR   | lock seen, GSR/PRLD held for ROC_CYCLES
// HOLD_GTS   | GSR released, GTS held for TOC_CYCLES
// HOLD_GWE   | GTS released, GWE withheld for GWE_DELAY
// DONE       | sequence complete, writes enabled
// FAULT      | lock never arrived, sticky until start
module startup_sequencer
    import startup_pkg::*;
#(
    parameter int ROC_CYCLES   = 1000,
    parameter int TOC_CYCLES   = 0,
    parameter int GWE_DELAY    = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic pll_locked,
    output logic gsr,
    output logic prld,
    output logic gts,
    output logic gwe,
    output logic done,
    output logic fault
);

    localparam logic [CNT_W-1:0] ROC_TC  = CNT_W'(ROC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOC_TC  = CNT_W'((TOC_CYCLES > 0) ? TOC_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GWE_TC  = CNT_W'(GWE_DELAY - 1);
    localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               SKIP_TOC = (TOC_CYCLES == 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    outs_t            r_outs;
    logic             w_lock_s;

    sync2 u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_lock_s)
    );

    // Counters only advance below their terminal value, so none can wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_outs  <= OUT_ALL_HELD;
        end else begin
            r_outs <= decode_outputs(r_state);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= ST_HOLD_GSR;
                        r_cnt   <= '0;
                    end else if (r_cnt == LOCK_TC) begin
                        r_state <= ST_FAULT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HOLD_GSR: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == ROC_TC) begin
                        r_state <= SKIP_TOC ? ST_HOLD_GWE : ST_HOLD_GTS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HOLD_GTS: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == TOC_TC) begin
                        r_state <= ST_HOLD_GWE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HOLD_GWE: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == GWE_TC) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                end
                ST_FAULT: begin
                    if (start) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign gsr   = r_outs.gsr;
    assign prld  = r_outs.gsr;
    assign gts   = r_outs.gts;
    assign gwe   = r_outs.gwe;
    assign done  = r_outs.done;
    assign fault = r_outs.fault;

endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: two instances (TOC=2 and TOC=0) driven in
// lockstep, directed timing tables plus a random phase against a timeline model.
module tb_startup_sequencer;

    localparam int ROC = 8;
    localparam int TOC = 2;
    localparam int GWE = 3;
    localparam int LT  = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pll_locked = 1'b0;

    logic a_gsr, a_prld, a_gts, a_gwe, a_done, a_fault;
    logic b_gsr, b_prld, b_gts, b_gwe, b_done, b_fault;
    logic [5:0] out_a, out_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    startup_sequencer #(
        .ROC_CYCLES(ROC), .TOC_CYCLES(TOC), .GWE_DELAY(GWE), .LOCK_TIMEOUT(LT)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .pll_locked(pll_locked),
        .gsr(a_gsr), .prld(a_prld), .gts(a_gts), .gwe(a_gwe), .done(a_done), .fault(a_fault)
    );

    startup_sequencer #(
        .ROC_CYCLES(ROC), .TOC_CYCLES(0), .GWE_DELAY(GWE), .LOCK_TIMEOUT(LT)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .pll_locked(pll_locked),
        .gsr(b_gsr), .prld(b_prld), .gts(b_gts), .gwe(b_gwe), .done(b_done), .fault(b_fault)
    );

    assign out_a = {a_gsr, a_prld, a_gts, a_gwe, a_done, a_fault};
    assign out_b = {b_gsr, b_prld, b_gts, b_gwe, b_done, b_fault};

    // Timeline model: mode plus elapsed cycles since lock was first seen.
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_SEQ   = 2;
    localparam int M_FAULT = 3;

    typedef struct {
        int   mode;
        int   wcnt;
        int   seq_t;
        logic s1;
        logic s2;
    } mdl_t;

    function automatic logic [5:0] mdl_out(input mdl_t m, input int toc);
        logic g_sr, g_ts, g_we, flt;
        g_sr = 1'b1;
        g_ts = 1'b1;
        g_we = 1'b0;
        flt  = (m.mode == M_FAULT);
        if (m.mode == M_SEQ) begin
            g_sr = (m.seq_t < ROC);
            g_ts = (m.seq_t < ROC + toc);
            g_we = (m.seq_t >= ROC + toc + GWE);
        end
        return {g_sr, g_sr, g_ts, g_we, g_we, flt};
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic rst_ok, input logic st,
                                      input logic pll, input int toc);
        mdl_t n;
        logic ls;
        n = m;
        if (!rst_ok) begin
            n.mode = M_IDLE; n.wcnt = 0; n.seq_t = 0; n.s1 = 1'b0; n.s2 = 1'b0;
            return n;
        end
        ls   = m.s2;
        n.s2 = m.s1;
        n.s1 = pll;
        case (m.mode)
            M_IDLE, M_FAULT: if (st) begin n.mode = M_WAIT; n.wcnt = 0; end
            M_WAIT: begin
                if (ls) begin
                    n.mode = M_SEQ; n.seq_t = 0;
                end else if (m.wcnt == LT - 1) begin
                    n.mode = M_FAULT;
                end else begin
                    n.wcnt = m.wcnt + 1;
                end
            end
            default: begin
                if (!ls) begin
                    n.mode = M_WAIT; n.wcnt = 0;
                end else if (m.seq_t < ROC + toc + GWE) begin
                    n.seq_t = m.seq_t + 1;
                end
            end
        endcase
        return n;
    endfunction

    mdl_t ma, mb;
    logic [5:0] exp_a, exp_b;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_a = 6'b111000;
            exp_b = 6'b111000;
        end else begin
            exp_a = mdl_out(ma, TOC);
            exp_b = mdl_out(mb, 0);
        end
        ma = mdl_step(ma, rst_n, start, pll_locked, TOC);
        mb = mdl_step(mb, rst_n, start, pll_locked, 0);
    end

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (gsr,prld,gts,gwe,done,fault) at %0t",
                     name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a", out_a, exp_a);
            check("model_b", out_b, exp_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int         k;
        logic [5:0] ea;
        logic [5:0] eb;
    } vec_t;

    vec_t nom[9];
    vec_t rel[5];

    initial begin
        int k;
        // nominal: cycles after the start edge, expected outputs for TOC=2 / TOC=0
        nom[0] = '{1,  6'b111000, 6'b111000};
        nom[1] = '{9,  6'b111000, 6'b111000};
        nom[2] = '{10, 6'b001000, 6'b000000};
        nom[3] = '{11, 6'b001000, 6'b000000};
        nom[4] = '{12, 6'b000000, 6'b000000};
        nom[5] = '{13, 6'b000000, 6'b000110};
        nom[6] = '{14, 6'b000000, 6'b000110};
        nom[7] = '{15, 6'b000110, 6'b000110};
        nom[8] = '{16, 6'b000110, 6'b000110};
        // relock: ticks after pll_locked returns high
        rel[0] = '{11, 6'b111000, 6'b111000};
        rel[1] = '{12, 6'b001000, 6'b000000};
        rel[2] = '{14, 6'b000000, 6'b000000};
        rel[3] = '{16, 6'b000000, 6'b000110};
        rel[4] = '{17, 6'b000110, 6'b000110};

        rst_n = 1'b0; start = 1'b0; pll_locked = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset_a", out_a, 6'b111000);
        check("reset_b", out_b, 6'b111000);
        rst_n = 1'b1;
        repeat (4) tick();

        start = 1'b1; tick(); start = 1'b0; k = 0;
        for (int i = 0; i < 9; i++) begin
            while (k < nom[i].k) begin tick(); k++; end
            check("nominal_a", out_a, nom[i].ea);
            check("nominal_b", out_b, nom[i].eb);
        end

        pll_locked = 1'b0;
        repeat (3) tick();
        check("lockloss_hold_a", out_a, 6'b000110);
        check("lockloss_hold_b", out_b, 6'b000110);
        tick();
        check("lockloss_drop_a", out_a, 6'b111000);
        check("lockloss_drop_b", out_b, 6'b111000);
        pll_locked = 1'b1; k = 0;
        for (int i = 0; i < 5; i++) begin
            while (k < rel[i].k) begin tick(); k++; end
            check("relock_a", out_a, rel[i].ea);
            check("relock_b", out_b, rel[i].eb);
        end

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        repeat (4) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        check("midgts_pre_a", out_a, 6'b001000);
        rst_n = 1'b0; start = 1'b1; tick(); rst_n = 1'b1; start = 1'b0;
        check("midgts_rst_a", out_a, 6'b111000);
        check("midgts_rst_b", out_b, 6'b111000);
        repeat (20) tick();
        check("midgts_stay_a", out_a, 6'b111000);
        check("midgts_stay_b", out_b, 6'b111000);

        pll_locked = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        check("timeout_pre_a", out_a, 6'b111000);
        check("timeout_pre_b", out_b, 6'b111000);
        tick();
        check("timeout_a", out_a, 6'b111001);
        check("timeout_b", out_b, 6'b111001);
        repeat (5) tick();
        check("fault_sticky_a", out_a, 6'b111001);
        start = 1'b1; tick(); start = 1'b0;
        check("fault_exit_lag_a", out_a, 6'b111001);
        tick();
        check("fault_exit_a", out_a, 6'b111000);
        check("fault_exit_b", out_b, 6'b111000);

        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
